// File: rtl/alu_writeback_if.sv
// ALU -> writeback stage bus: EXE-side handshake, register-file write port,
// and the forwarding tap back to operand select.
interface alu_writeback_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_overflow;
  logic [REG_AW-1:0] in_rd;
  logic              in_we;
  logic              in_setf;

  logic              wb_ready;
  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;

  // ALU / register-file / operand-select side
  modport master (
    output in_valid, in_result, in_overflow, in_rd, in_we, in_setf, wb_ready,
    input  in_ready, wb_we, wb_addr, wb_data, fwd_valid, fwd_addr, fwd_data
  );

  // Writeback stage side
  modport slave (
    input  in_valid, in_result, in_overflow, in_rd, in_we, in_setf, wb_ready,
    output in_ready, wb_we, wb_addr, wb_data, fwd_valid, fwd_addr, fwd_data
  );
endinterface

// File: rtl/alu_writeback_stage.sv
// EXE->WB stage: 2-entry skid FIFO (slot 0 = head, slot 1 = second), register-file
// write port, N/Z/V flags and forwarding of the youngest buffered entry.
// Optional feature macro: OVF_TRAP_EN (overflowing writes trap instead of retiring
// a write; stage stalls until trap_ack).
module alu_writeback_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               trap_ack,
  alu_writeback_if.slave     bus,
  output logic               flag_n,
  output logic               flag_z,
  output logic               flag_v,
  output logic               ovf_trap
);

  logic [DATA_W-1:0] res_q  [2];
  logic [REG_AW-1:0] rd_q   [2];
  logic              ovf_q  [2];
  logic              we_q   [2];
  logic              setf_q [2];
  logic [1:0]        count_q;
  logic              trap_q;

  logic              ready;
  logic              push;
  logic              pop;
  logic              trap_hit;
  logic              young;

  // Handshake decode; flush and a pending trap both freeze the FIFO
  always_comb begin
    ready    = (count_q != 2'd2) && !trap_q;
    push     = bus.in_valid && ready && !flush;
    pop      = (count_q != 2'd0) && bus.wb_ready && !flush && !trap_q;
`ifdef OVF_TRAP_EN
    trap_hit = ovf_q[0] && we_q[0];
`else
    trap_hit = 1'b0;
`endif
    young    = (count_q == 2'd2);
  end

  assign bus.in_ready  = ready;
  assign bus.wb_we     = pop && we_q[0] && (rd_q[0] != '0) && !trap_hit;
  assign bus.wb_addr   = rd_q[0];
  assign bus.wb_data   = res_q[0];
  assign bus.fwd_valid = (count_q != 2'd0) && we_q[young] && (rd_q[young] != '0);
  assign bus.fwd_addr  = rd_q[young];
  assign bus.fwd_data  = res_q[young];
  assign ovf_trap      = trap_q;

  // FIFO storage and occupancy; head slot keeps its last contents when emptied
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        res_q[i]  <= '0;
        rd_q[i]   <= '0;
        ovf_q[i]  <= 1'b0;
        we_q[i]   <= 1'b0;
        setf_q[i] <= 1'b0;
      end
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      if (pop && (count_q == 2'd2)) begin
        res_q[0]  <= res_q[1];
        rd_q[0]   <= rd_q[1];
        ovf_q[0]  <= ovf_q[1];
        we_q[0]   <= we_q[1];
        setf_q[0] <= setf_q[1];
      end
      if (push) begin
        if ((count_q == 2'd0) || pop) begin
          res_q[0]  <= bus.in_result;
          rd_q[0]   <= bus.in_rd;
          ovf_q[0]  <= bus.in_overflow;
          we_q[0]   <= bus.in_we;
          setf_q[0] <= bus.in_setf;
        end else begin
          res_q[1]  <= bus.in_result;
          rd_q[1]   <= bus.in_rd;
          ovf_q[1]  <= bus.in_overflow;
          we_q[1]   <= bus.in_we;
          setf_q[1] <= bus.in_setf;
        end
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  // Status flags follow the retiring head when it requests a flag update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
    end else if (pop && setf_q[0]) begin
      flag_n <= res_q[0][DATA_W-1];
      flag_z <= (res_q[0] == '0);
      flag_v <= ovf_q[0];
    end
  end

`ifdef OVF_TRAP_EN
  // Sticky overflow trap; a new trap takes priority over a simultaneous ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trap_q <= 1'b0;
    end else if (pop && trap_hit) begin
      trap_q <= 1'b1;
    end else if (trap_ack) begin
      trap_q <= 1'b0;
    end
  end
`else
  assign trap_q = 1'b0;
  logic unused_trap_ack;
  assign unused_trap_ack = trap_ack;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboarded bench for alu_writeback_stage: directed vectors push expected
// register-file writes; a negedge monitor retires them against wb_we.
module tb_alu_writeback_stage;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic trap_ack = 1'b0;
  logic flag_n, flag_z, flag_v, ovf_trap;

  alu_writeback_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  alu_writeback_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .trap_ack (trap_ack),
    .bus      (bus),
    .flag_n   (flag_n),
    .flag_z   (flag_z),
    .flag_v   (flag_v),
    .ovf_trap (ovf_trap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [REG_AW+DATA_W-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst && bus.wb_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_queue_size", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [REG_AW+DATA_W-1:0] e;
        e = exp_q.pop_front();
        check("wb_addr", 64'(bus.wb_addr), 64'(e[REG_AW+DATA_W-1:DATA_W]));
        check("wb_data", 64'(bus.wb_data), 64'(e[DATA_W-1:0]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one op and hold it across one accepting edge
  task automatic push(input logic [31:0] res, input logic ovf, input logic [4:0] rd,
                      input logic we, input logic setf, input bit expect_wr);
    int t = 0;
    bus.in_result   = res;
    bus.in_overflow = ovf;
    bus.in_rd       = rd;
    bus.in_we       = we;
    bus.in_setf     = setf;
    #1;
    while (!bus.in_ready && t < 20) begin
      step(1);
      t++;
    end
    check("push_ready_in_time", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    if (expect_wr) exp_q.push_back({rd, res});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_result = '0; bus.in_overflow = 1'b0;
    bus.in_rd = '0; bus.in_we = 1'b0; bus.in_setf = 1'b0; bus.wb_ready = 1'b0;

    // Reset state
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_outputs", 64'({bus.wb_we, bus.fwd_valid, flag_n, flag_z, flag_v, ovf_trap}), 64'd0);
    check("rst_wb_fields", 64'({bus.wb_addr, bus.wb_data}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(1);

    // Single op: write strobe in the cycle after acceptance, then flags
    bus.wb_ready = 1'b1;
    push(32'hFFFF_FFFE, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1);
    check("single_wb_we", 64'(bus.wb_we), 64'd1);
    check("single_wb_addr", 64'(bus.wb_addr), 64'd3);
    check("single_fwd", 64'({bus.fwd_valid, bus.fwd_addr, bus.fwd_data}), 64'({1'b1, 5'd3, 32'hFFFF_FFFE}));
    step(1);
    check("single_flags_nzv", 64'({flag_n, flag_z, flag_v}), 64'b100);
    check("single_empty_fwd", 64'(bus.fwd_valid), 64'd0);

    // Backpressure: third op refused, then two writes in order, one per cycle
    bus.wb_ready = 1'b0;
    push(32'h0000_0011, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
    push(32'h0000_0022, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
    bus.in_result = 32'h33; bus.in_rd = 5'd9; bus.in_valid = 1'b1;
    #1;
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_fwd_youngest", 64'({bus.fwd_addr, bus.fwd_data}), 64'({5'd6, 32'h22}));
    step(1);
    check("full_hold_ready", 64'({bus.in_ready, bus.wb_we}), 64'd0);
    bus.in_valid = 1'b0;
    bus.wb_ready = 1'b1;
    #1;
    check("drain0_addr", 64'({bus.wb_we, bus.wb_addr}), 64'({1'b1, 5'd5}));
    step(1);
    check("drain1_addr", 64'({bus.wb_we, bus.wb_addr}), 64'({1'b1, 5'd6}));
    step(1);
    check("drain_done", 64'(bus.wb_we), 64'd0);
    check("nonsetf_flags_held", 64'({flag_n, flag_z, flag_v}), 64'b100);

    // rd=0: retires without write or forward, Z set
    push(32'h0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    check("rd0_wb_we", 64'(bus.wb_we), 64'd0);
    check("rd0_fwd_valid", 64'(bus.fwd_valid), 64'd0);
    step(1);
    check("rd0_flags_nzv", 64'({flag_n, flag_z, flag_v}), 64'b010);

    // Flush beats simultaneous accept and drain
    bus.wb_ready = 1'b0;
    push(32'h8000_0000, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    push(32'h0000_0001, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_result = 32'h5; bus.in_rd = 5'd10;
    bus.wb_ready = 1'b1;
    #1;
    check("flush_no_write", 64'(bus.wb_we), 64'd0);
    step(1);
    flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    check("flush_empty", 64'({bus.in_ready, bus.wb_we, bus.fwd_valid}), 64'b100);
    check("flush_flags_held", 64'({flag_n, flag_z, flag_v}), 64'b010);
    step(2);

`ifdef OVF_TRAP_EN
    // Overflow trap: write suppressed, stage stalls until acknowledged
    push(32'h0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
    check("trap_no_write", 64'(bus.wb_we), 64'd0);
    step(1);
    check("trap_set", 64'({ovf_trap, bus.in_ready}), 64'b10);
    check("trap_flags_nzv", 64'({flag_n, flag_z, flag_v}), 64'b011);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    #1;
    check("trap_survives_flush", 64'({ovf_trap, bus.in_ready}), 64'b10);
    trap_ack = 1'b1;
    step(1);
    trap_ack = 1'b0;
    #1;
    check("trap_cleared", 64'({ovf_trap, bus.in_ready}), 64'b01);
`else
    // Overflow without trap: write happens, V set
    push(32'h0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1);
    check("ovf_write", 64'({bus.wb_we, bus.wb_addr}), 64'({1'b1, 5'd9}));
    step(1);
    check("ovf_flags_nzv", 64'({flag_n, flag_z, flag_v}), 64'b011);
    trap_ack = 1'b1;
    step(1);
    trap_ack = 1'b0;
    check("ovf_trap_tied", 64'(ovf_trap), 64'd0);
`endif

    // Mid-stream reset with a full FIFO discards entries
    bus.wb_ready = 1'b0;
    push(32'h0000_AAAA, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
    push(32'h0000_5555, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
    check("pre_reset_full", 64'(bus.in_ready), 64'd0);
    #2;
    rst = 1'b0;
    bus.wb_ready = 1'b1;
    #1;
    check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_outputs", 64'({bus.wb_we, bus.fwd_valid, flag_n, flag_z, flag_v, ovf_trap}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(2);
    check("post_rst_no_write", 64'(bus.wb_we), 64'd0);

    // Recovery after reset
    push(32'h0000_1234, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
    check("recover_write", 64'({bus.wb_we, bus.wb_addr}), 64'({1'b1, 5'd4}));
    step(3);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
